// File: rtl/branch_target_lut.sv
// Branch target lookup table: DEPTH entries of (value, rel flag), registered lookup with write bypass.
// Latency: 1 cycle from request edge to Target/OutValid; table writes commit at the same edge.
// Backpressure: Stall freezes Target/OutValid and drops requests; writes still commit. Macro BRANCH_LUT_RELATIVE_EN enables PC-relative entries.
module branch_target_lut #(
    parameter int IDX_W       = 4,
    parameter int ADDR_W      = 10,
    parameter int DEFAULT_TGT = 1
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              ReqValid,
    input  logic [IDX_W-1:0]  Index,
    input  logic [ADDR_W-1:0] PC,
    input  logic              Stall,
    input  logic              WrEn,
    input  logic [IDX_W-1:0]  WrIndex,
    input  logic [ADDR_W-1:0] WrData,
    input  logic              WrRel,
    output logic [ADDR_W-1:0] Target,
    output logic              OutValid,
    output logic [7:0]        WrCount
);

    localparam int DEPTH = 2 ** IDX_W;

    logic [ADDR_W-1:0] tbl_val [DEPTH];
    logic              byp_hit;
    logic [ADDR_W-1:0] sel_val;
    logic [ADDR_W-1:0] resolved;

    // Entry values: reset to the default target, overwritten by the write port
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_val[i] <= ADDR_W'(DEFAULT_TGT);
            end
        end else if (WrEn) begin
            tbl_val[WrIndex] <= WrData;
        end
    end

`ifdef BRANCH_LUT_RELATIVE_EN
    logic tbl_rel [DEPTH];
    logic sel_rel;

    // Relative flags: default entries mean PC + DEFAULT_TGT after reset
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                tbl_rel[i] <= 1'b1;
            end
        end else if (WrEn) begin
            tbl_rel[WrIndex] <= WrRel;
        end
    end

    // Select entry (bypassing a same-index write) and resolve against the request PC
    always_comb begin
        byp_hit  = WrEn && (WrIndex == Index);
        sel_val  = byp_hit ? WrData : tbl_val[Index];
        sel_rel  = byp_hit ? WrRel  : tbl_rel[Index];
        resolved = sel_rel ? (PC + sel_val) : sel_val;
    end
`else
    // PC and WrRel have no meaning when every entry is absolute
    logic unused_rel_inputs;
    assign unused_rel_inputs = ^{PC, WrRel};

    // Select entry, bypassing a same-index write; entries are always absolute
    always_comb begin
        byp_hit  = WrEn && (WrIndex == Index);
        sel_val  = byp_hit ? WrData : tbl_val[Index];
        resolved = sel_val;
    end
`endif

    // Output register: loads on an unstalled request, holds under Stall
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Target   <= '0;
            OutValid <= 1'b0;
        end else if (!Stall) begin
            OutValid <= ReqValid;
            if (ReqValid) begin
                Target <= resolved;
            end
        end
    end

    // Saturating count of committed writes
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            WrCount <= 8'd0;
        end else if (WrEn && (WrCount != 8'hFF)) begin
            WrCount <= WrCount + 8'd1;
        end
    end

endmodule

// File: doc/branch_target_lut.md
BRANCH_TARGET_LUT -- requirements
Module: branch_target_lut

Interface
- REQ-001: Parameter IDX_W, default 4: lookup index width; DEPTH = 2**IDX_W entries.
- REQ-002: Parameter ADDR_W, default 10: target/PC width.
- REQ-003: Parameter DEFAULT_TGT, default 1: per-entry reset value; means PC+1 in relative mode.
- REQ-004: The block SHALL use one clock; reset SHALL be asynchronous and active-low.
- REQ-005: Clk  in  1  rising-edge clock.
- REQ-006: Reset_n  in  1  asynchronous active-low reset.
- REQ-007: ReqValid  in  1  lookup request.
- REQ-008: Index  in  IDX_W  lookup entry.
- REQ-009: PC  in  ADDR_W  current PC; used only in relative mode.
- REQ-010: Stall  in  1  freezes the output register.
- REQ-011: WrEn  in  1  table write strobe.
- REQ-012: WrIndex  in  IDX_W  entry to write.
- REQ-013: WrData  in  ADDR_W  new entry value.
- REQ-014: WrRel  in  1  new entry's relative flag.
- REQ-015: Target  out  ADDR_W  registered lookup result.
- REQ-016: OutValid  out  1  Target holds a result for a request.
- REQ-017: WrCount  out  8  saturating count of accepted writes.

Function
- REQ-018: Storage SHALL be DEPTH entries, each holding a value (ADDR_W bits) and a rel flag.
- REQ-019: Lookup latency SHALL be 1 cycle.
  - Edge with ReqValid=1 and Stall=0: Target loads the resolved value and OutValid=1.
  - Edge with ReqValid=0 and Stall=0: OutValid=0 and Target holds its last value.
- REQ-020: While Stall=1, Target and OutValid SHALL hold.
  - Writes still commit.
  - Requests presented during Stall are dropped, not queued.
- REQ-021: A write SHALL commit at the rising edge with WrEn=1, and is independent of Stall.
- REQ-022: Read-during-write to the same index in the same cycle SHALL return the new WrData/WrRel (bypass).
  - A different index returns the stored entry.
- REQ-023: WrCount SHALL increment by 1 per committed write and saturate at 255.
- REQ-024: Resolved value SHALL be the entry value when rel=0, and per REQ-031 when rel=1.
- REQ-025: All arithmetic SHALL be modulo 2**ADDR_W.
  - Example: ADDR_W=10, PC=0x005, entry 0x3F0 -> 0x3F5.
- REQ-026: The block SHALL have no other states; behaviour SHALL be fully determined by the table, the output register and WrCount.

Reset
- REQ-027: On Reset_n=0, asynchronously:
  - every entry value = DEFAULT_TGT;
  - every rel flag = 1 when BRANCH_LUT_RELATIVE_EN is defined, else 0;
  - Target = 0, OutValid = 0, WrCount = 0.
- REQ-028: Reset asserted mid-operation SHALL discard any in-flight lookup and write in that cycle.
- REQ-029: The first request SHALL be accepted at the first rising edge after Reset_n deasserts.

Configuration
- REQ-030: Macro BRANCH_LUT_RELATIVE_EN SHALL select the PC-relative feature.
- REQ-031: Defined: rel=1 entries resolve to PC + value.
  - The value is a two's-complement offset.
  - PC is sampled at the request edge (bypass case uses the same PC).
- REQ-032: Undefined:
  - PC is ignored;
  - WrRel is ignored and every stored rel flag reads 0;
  - Target is always the absolute entry value.

Verification
- REQ-033: Reset, then ReqValid=1 with Index=3 and PC=0x010.
  - Relative build: Target=0x011 next cycle.
  - Absolute build: Target=0x001.
  - In both builds OutValid=1.
- REQ-034: Write idx 2 = 0x3F0 with rel=1, then request idx 2 with PC=0x020 (relative build) -> Target=0x010.
- REQ-035: Same-cycle write idx 5 = 0x123 (rel=0) and request idx 5 -> Target=0x123 next cycle.
  - Also, same-cycle write idx 6 and request idx 5 -> old idx-5 value returned.
- REQ-036: Request idx 1, then hold Stall=1 for 3 cycles with a new request and a write to idx 1.
  - Target and OutValid stay unchanged during the stall.
  - A later request to idx 1 returns the written value.
- REQ-037: Issue 260 writes -> WrCount=255.
  - Assert Reset_n=0 mid-cycle -> WrCount=0, OutValid=0 immediately, with no clock edge needed.
